// File: rtl/lcd_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_line_writer
// Description : HD44780-style 4-bit LCD driver. Runs the power-on init, then
//               writes two latched 16-character lines per display_start request.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_line_writer #(
    parameter int INIT_CYC       = 750000,
    parameter int E_HIGH_CYC     = 12,
    parameter int SETUP_CYC      = 2,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int CHAR_GAP_CYC   = 2000,
    parameter int CLEAR_CYC      = 82000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [0:127]   first_line,
    input  logic [0:127]   second_line,
    input  logic           display_start,
    output logic           LCD_RS,
    output logic           LCD_RW,
    output logic           LCD_E,
    output logic [3:0]     data_stream,
    output logic           display_end
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = f_max(f_max(f_max(INIT_CYC, E_HIGH_CYC), f_max(SETUP_CYC, NIBBLE_GAP_CYC)),
                                   f_max(CHAR_GAP_CYC, CLEAR_CYC));
    localparam int CW = $clog2(MAX_CYC + 2);

    localparam logic [31:0] C_INIT  = 32'(INIT_CYC);
    localparam logic [31:0] C_EHIGH = 32'(E_HIGH_CYC);
    localparam logic [31:0] C_SETUP = 32'(SETUP_CYC);
    localparam logic [31:0] C_NGAP  = 32'(NIBBLE_GAP_CYC);
    localparam logic [31:0] C_CGAP  = 32'(CHAR_GAP_CYC);
    localparam logic [31:0] C_CLEAR = 32'(CLEAR_CYC);

    typedef enum logic [2:0] {
        INIT_WAIT = 3'd0,
        INIT_SEQ  = 3'd1,
        IDLE      = 3'd2,
        FRAME     = 3'd3,
        DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHIGH = 2'd1,
        PH_HOLD  = 2'd2,
        PH_GAP   = 2'd3
    } phase_t;

    state_t          r_state, w_state;
    phase_t          r_phase, w_phase;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic [6:0]      r_idx,   w_idx;
    logic            r_e,     w_e;
    logic            r_rs,    w_rs;
    logic [3:0]      r_data,  w_data;
    logic            r_end,   w_end;
    logic [0:127]    r_line1, r_line2;

    logic            w_accept;
    logic            w_load;
    logic            w_adv;
    logic            w_last;
    logic [31:0]     w_cnt_inc;
    logic [31:0]     w_gap_len;
    logic [0:127]    w_l1, w_l2;

    // Nibble selection: idx counts nibbles, so idx[6:1] is the byte and idx[0] the half.
    function automatic logic [4:0] f_nib(input logic is_init, input logic [6:0] idx,
                                         input logic [0:127] l1, input logic [0:127] l2);
        logic [5:0] b;
        logic [3:0] k;
        logic [7:0] byt;
        logic       rs;
        b   = idx[6:1];
        k   = 4'd0;
        byt = 8'h00;
        rs  = 1'b0;
        if (is_init) begin
            case (idx)
                7'd0, 7'd1, 7'd2: byt[3:0] = 4'h3;
                7'd3, 7'd4:       byt[3:0] = 4'h2;
                7'd5:             byt[3:0] = 4'h8;
                7'd7:             byt[3:0] = 4'h6;
                7'd9:             byt[3:0] = 4'hC;
                7'd11:            byt[3:0] = 4'h1;
                default:          byt[3:0] = 4'h0;
            endcase
            return {1'b0, byt[3:0]};
        end
        if (b == 6'd0) begin
            byt = 8'h80;
        end else if (b <= 6'd16) begin
            k   = 4'(b - 6'd1);
            byt = l1[{k, 3'b000} +: 8];
            rs  = 1'b1;
        end else if (b == 6'd17) begin
            byt = 8'hC0;
        end else begin
            k   = 4'(b - 6'd18);
            byt = l2[{k, 3'b000} +: 8];
            rs  = 1'b1;
        end
        return {rs, (idx[0] ? byt[3:0] : byt[7:4])};
    endfunction

    assign w_accept  = (r_state == IDLE) && display_start;
    assign w_cnt_inc = 32'(r_cnt) + 32'd1;
    assign w_l1      = w_accept ? first_line  : r_line1;
    assign w_l2      = w_accept ? second_line : r_line2;

    // Init nibbles 0-3 stand alone; from 4 on, even idx is a high nibble.
    always_comb begin
        w_gap_len = C_CGAP;
        w_last    = 1'b0;
        if (r_state == INIT_SEQ) begin
            w_last = (r_idx == 7'd11);
            if (r_idx < 7'd4)
                w_gap_len = C_CGAP;
            else if (r_idx == 7'd11)
                w_gap_len = C_CLEAR;
            else if (!r_idx[0])
                w_gap_len = C_NGAP;
        end else begin
            w_last    = (r_idx == 7'd67);
            w_gap_len = r_idx[0] ? C_CGAP : C_NGAP;
        end
    end

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_e     = r_e;
        w_rs    = r_rs;
        w_data  = r_data;
        w_end   = r_end;
        w_load  = 1'b0;
        w_adv   = 1'b0;

        unique case (r_state)
            INIT_WAIT: begin
                if (w_cnt_inc >= C_INIT) begin
                    w_state = INIT_SEQ;
                    w_idx   = 7'd0;
                    w_load  = 1'b1;
                end else begin
                    w_cnt = CW'(w_cnt_inc);
                end
            end
            INIT_SEQ, FRAME: begin
                unique case (r_phase)
                    PH_SETUP: begin
                        if (w_cnt_inc >= C_SETUP) begin
                            w_phase = PH_EHIGH;
                            w_e     = 1'b1;
                            w_cnt   = '0;
                        end else begin
                            w_cnt = CW'(w_cnt_inc);
                        end
                    end
                    PH_EHIGH: begin
                        if (w_cnt_inc >= C_EHIGH) begin
                            w_phase = PH_HOLD;
                            w_e     = 1'b0;
                            w_cnt   = '0;
                        end else begin
                            w_cnt = CW'(w_cnt_inc);
                        end
                    end
                    PH_HOLD: begin
                        if (w_gap_len == 32'd0) begin
                            w_adv = 1'b1;
                        end else begin
                            w_phase = PH_GAP;
                            w_cnt   = '0;
                        end
                    end
                    default: begin
                        if (w_cnt_inc >= w_gap_len)
                            w_adv = 1'b1;
                        else
                            w_cnt = CW'(w_cnt_inc);
                    end
                endcase
                if (w_adv) begin
                    if (w_last) begin
                        w_cnt = '0;
                        if (r_state == INIT_SEQ) begin
                            w_state = IDLE;
                        end else begin
                            w_state = DONE;
                            w_end   = 1'b1;
                        end
                    end else begin
                        w_idx  = r_idx + 7'd1;
                        w_load = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (display_start) begin
                    w_state = FRAME;
                    w_idx   = 7'd0;
                    w_load  = 1'b1;
                end
            end
            DONE: begin
                if (!display_start) begin
                    w_end   = 1'b0;
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = INIT_WAIT;
                w_cnt   = '0;
            end
        endcase

        // A zero setup time raises E on the same edge that presents the data.
        if (w_load) begin
            w_cnt          = '0;
            {w_rs, w_data} = f_nib(w_state == INIT_SEQ, w_idx, w_l1, w_l2);
            if (SETUP_CYC == 0) begin
                w_phase = PH_EHIGH;
                w_e     = 1'b1;
            end else begin
                w_phase = PH_SETUP;
                w_e     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT_WAIT;
            r_phase <= PH_SETUP;
            r_cnt   <= '0;
            r_idx   <= 7'd0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 4'h0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_e     <= w_e;
            r_rs    <= w_rs;
            r_data  <= w_data;
            r_end   <= w_end;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line1 <= first_line;
            r_line2 <= second_line;
        end
    end

    assign LCD_RS      = r_rs;
    assign LCD_RW      = 1'b0;
    assign LCD_E       = r_e;
    assign data_stream = r_data;
    assign display_end = r_end;

endmodule
`default_nettype wire

// File: tb/tb_lcd_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_line_writer
// Description : Self-checking bench; a per-cycle timeline model of the LCD pins
//               is compared against the DUT on every sample after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_line_writer;

    localparam int P_INIT = 20;
    localparam int P_EH   = 3;
    localparam int P_SU   = 2;
    localparam int P_NG   = 2;
    localparam int P_CG   = 4;
    localparam int P_CL   = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:127] l1, l2;
    logic         start;
    logic         LCD_RS, LCD_RW, LCD_E, display_end;
    logic [3:0]   data_stream;

    always #5 clk = ~clk;

    lcd_line_writer #(
        .INIT_CYC(P_INIT), .E_HIGH_CYC(P_EH), .SETUP_CYC(P_SU),
        .NIBBLE_GAP_CYC(P_NG), .CHAR_GAP_CYC(P_CG), .CLEAR_CYC(P_CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .first_line(l1), .second_line(l2),
        .display_start(start), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E),
        .data_stream(data_stream), .display_end(display_end)
    );

    // Expected sample: {rw, e, rs, end, data[3:0]}
    logic [7:0]   q[$];
    logic [4:0]   pq[$];
    logic         lrs;
    logic [3:0]   ld;
    int           n_pass, n_total;
    int           smp, rises, first_rise;
    logic         prev_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_s(input logic e, input logic en);
        q.push_back({1'b0, e, lrs, en, ld});
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] d, input int gap);
        lrs = rs;
        ld  = d;
        pq.push_back({rs, d});
        repeat (P_SU) push_s(1'b0, 1'b0);
        repeat (P_EH) push_s(1'b1, 1'b0);
        push_s(1'b0, 1'b0);
        repeat (gap) push_s(1'b0, 1'b0);
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4], P_NG);
        push_nib(rs, b[3:0], (!rs && b == 8'h01) ? P_CL : P_CG);
    endtask

    task automatic push_init();
        lrs = 1'b0;
        ld  = 4'h0;
        repeat (P_INIT) push_s(1'b0, 1'b0);
        push_nib(1'b0, 4'h3, P_CG);
        push_nib(1'b0, 4'h3, P_CG);
        push_nib(1'b0, 4'h3, P_CG);
        push_nib(1'b0, 4'h2, P_CG);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [0:127] a, input logic [0:127] b);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_byte(1'b1, a[8*k +: 8]);
        push_byte(1'b0, 8'hC0);
        for (int k = 0; k < 16; k++) push_byte(1'b1, b[8*k +: 8]);
    endtask

    task automatic push_idle(input int n, input logic en);
        repeat (n) push_s(1'b0, en);
    endtask

    // One sample at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        logic [7:0] ex, ac;
        @(negedge clk);
        if (!rst_n) begin
            smp = 0; rises = 0; first_rise = -1; prev_e = 1'b0;
        end else begin
            if (LCD_E && !prev_e) begin
                rises++;
                if (first_rise < 0) first_rise = smp;
            end
            prev_e = LCD_E;
            if (q.size() > 0) begin
                ex = q.pop_front();
                ac = {LCD_RW, LCD_E, LCD_RS, display_end, data_stream};
                chk($sformatf("sample %0d rw/e/rs/end/d", smp), 64'(ac), 64'(ex));
            end
            smp++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (q.size() > 0) cyc();
    endtask

    initial begin
        logic [47:0] v;
        logic [23:0] f6;
        int          fe, guard;
        n_pass = 0; n_total = 0;
        smp = 0; rises = 0; first_rise = -1; prev_e = 1'b0;
        rst_n = 1'b0;
        start = 1'b1;
        l1 = {16{8'h5A}};
        l2 = {16{8'h2D}};
        repeat (3) cyc();

        // Request held through init; lines change during init and after the 0x80 command.
        rst_n = 1'b1;
        pq.delete();
        push_init();
        push_idle(1, 1'b0);
        push_frame({"HELLO", {11{8'h20}}}, "0000000000000101");
        push_idle(50, 1'b1);

        v = '0;
        for (int i = 0; i < 12; i++) v = {v[43:0], pq[i][3:0]};
        chk("model init nibbles", 64'(v), 64'h3332_2806_0C01);
        chk("model pulse count", 64'(pq.size()), 64'd80);
        f6 = '0;
        for (int i = 12; i < 18; i++) f6 = {f6[19:0], pq[i][3:0]};
        chk("model frame head", 64'(f6), 64'h80_4845);
        chk("model row0 rs", 64'(pq[14][4]), 64'd1);
        chk("model C0 cmd", 64'(pq[46]), 64'h0C);
        fe = -1;
        for (int i = 0; i < q.size(); i++) if (fe < 0 && q[i][6]) fe = i;
        chk("model first E sample", 64'(fe), 64'd22);

        guard = 0;
        while (q.size() > 0) begin
            cyc();
            if (smp == 30) begin
                l1 = {"HELLO", {11{8'h20}}};
                l2 = "0000000000000101";
            end
            if (rises == 14) l1 = {16{8'h41}};
        end
        chk("first E rise cycle", 64'(first_rise), 64'd22);
        chk("pulses init+frame1", 64'(rises), 64'd80);

        // Handshake release, then a second frame.
        start = 1'b0;
        push_idle(1, 1'b1);
        push_idle(3, 1'b0);
        drain();
        l2 = "LCD LINE WRITER!";
        start = 1'b1;
        push_idle(1, 1'b0);
        push_frame(l1, l2);
        guard = 0;
        while (rises < 97 && guard < 5000) begin
            cyc();
            guard++;
        end
        chk("reached row0 char7", 64'(rises), 64'd97);

        // Asynchronous reset in the middle of row 0 character 7.
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("reset LCD_E", 64'(LCD_E), 64'd0);
        chk("reset LCD_RS", 64'(LCD_RS), 64'd0);
        chk("reset LCD_RW", 64'(LCD_RW), 64'd0);
        chk("reset data_stream", 64'(data_stream), 64'd0);
        chk("reset display_end", 64'(display_end), 64'd0);
        l2 = "abcdefghijklmnop";
        repeat (3) cyc();
        rst_n = 1'b1;
        pq.delete();
        push_init();
        push_idle(1, 1'b0);
        push_frame(l1, l2);
        push_idle(5, 1'b1);
        drain();
        chk("first E rise after reset", 64'(first_rise), 64'd22);
        chk("pulses init+frame3", 64'(rises), 64'd80);

        start = 1'b0;
        push_idle(1, 1'b1);
        push_idle(2, 1'b0);
        drain();
        chk("final display_end", 64'(display_end), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_line_writer.md
LCD_LINE_WRITER -- requirements
Module: lcd_line_writer

Interface
REQ-001 Parameter INIT_CYC, 750000, power-on wait in clk cycles before the first init nibble (15 ms at 50 MHz).
REQ-002 Parameter E_HIGH_CYC, 12, LCD_E high width in cycles.
REQ-003 Parameter SETUP_CYC, 2, cycles RS/data are stable with LCD_E low before each E rise.
REQ-004 Parameter NIBBLE_GAP_CYC, 50, idle cycles between the high and low nibble of one byte (1 us).
REQ-005 Parameter CHAR_GAP_CYC, 2000, idle cycles after each byte and after each init nibble (40 us).
REQ-006 Parameter CLEAR_CYC, 82000, idle cycles after the clear-display command (1.64 ms).
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 first_line  in  [0:127]  16 ASCII characters for row 0; character k = bits [8k:8k+7], so k=0 is the most-significant byte of a concatenation.
REQ-010 second_line  in  [0:127]  16 ASCII characters for row 1; same bit mapping.
REQ-011 display_start  in  1  level request to write both lines.
REQ-012 LCD_RS  out  1  0 = command, 1 = character data.
REQ-013 LCD_RW  out  1  constant 0 (write only).
REQ-014 LCD_E  out  1  enable strobe.
REQ-015 data_stream  out  4  LCD DB7..DB4; bit 3 = DB7.
REQ-016 display_end  out  1  frame-complete handshake flag.

Function
REQ-017 Every byte SHALL be sent as two nibbles, high nibble first.
REQ-018 Each nibble SHALL follow this sequence: RS/data driven with E low for SETUP_CYC cycles; E high for E_HIGH_CYC cycles; E low with RS/data held for 1 further cycle.
REQ-019 After the high nibble, the block SHALL wait NIBBLE_GAP_CYC cycles; after the low nibble, it SHALL wait CHAR_GAP_CYC cycles, or CLEAR_CYC cycles if the command was 0x01.
REQ-020 The init sequence SHALL run after reset: wait INIT_CYC; single nibbles 0x3, 0x3, 0x3, 0x2 (RS=0), each followed by CHAR_GAP_CYC; then command bytes 0x28, 0x06, 0x0C, 0x01 (12 E pulses in total).
REQ-021 The block SHALL use these states: INIT_WAIT, INIT_SEQ, IDLE, FRAME, DONE. Transitions: INIT_WAIT -> INIT_SEQ -> IDLE.
REQ-022 In IDLE with display_start=1, the block SHALL latch both lines within one cycle and enter FRAME.
REQ-023 Any change to first_line/second_line after the latch SHALL be ignored until the next acceptance.
REQ-024 FRAME SHALL send: command 0x80; 16 characters of row 0 (RS=1, k=0..15); command 0xC0; 16 characters of row 1. This is 34 bytes, 68 E pulses.
REQ-025 After the final gap, the block SHALL enter DONE and set display_end=1.
REQ-026 display_end SHALL be held at 1 until display_start is sampled 0; the block SHALL then clear display_end and return to IDLE one cycle later (4-phase handshake).
REQ-027 display_start SHALL be ignored outside IDLE; a level still held high when IDLE is reached SHALL be accepted then.
REQ-028 If display_start is still 1 when DONE exits, the block SHALL NOT start a new frame until display_start has returned low.
REQ-029 LCD_RW SHALL be 0 in every state; LCD_E SHALL never be high outside the E window of REQ-018.
REQ-030 Outside the nibble windows, data_stream and LCD_RS SHALL hold their last driven values.
REQ-031 All delay counters SHALL be wide enough for the largest parameter; a parameter value of 0 SHALL mean no wait.

Reset
REQ-032 rst_n=0 SHALL immediately force LCD_E=0, LCD_RS=0, LCD_RW=0, data_stream=0, display_end=0, all counters to 0 and the state to INIT_WAIT, independent of clk.
REQ-033 A reset mid-frame or mid-init SHALL abort the transfer; after release, the full init sequence of REQ-020 SHALL rerun before any frame is accepted.
REQ-034 Latched lines need no reset value.

Verification (INIT_CYC=20, E_HIGH_CYC=3, SETUP_CYC=2, NIBBLE_GAP_CYC=2, CHAR_GAP_CYC=4, CLEAR_CYC=10)
REQ-035 Release reset, no request -> first E rise exactly 22 cycles after reset release; 12 E pulses with nibbles 3,3,3,2,2,8,0,6,0,C,0,1, all with RS=0; 10-cycle gap after the last pulse; then IDLE.
REQ-036 first_line="HELLO" padded with 0x20, second_line="0000000000000101", hold display_start=1 -> 68 E pulses: 8,0,4,8,4,5,...; row 0 pulses RS=1; C,0 before row 1; display_end=1 after the final gap.
REQ-037 Hold display_start=1 for 50 cycles after display_end rises -> display_end stays 1 and no E pulse occurs; drop display_start -> display_end=0 within 2 cycles.
REQ-038 Assert display_start during INIT_SEQ -> no row data until init completes; frame then starts from IDLE with the lines latched at that point.
REQ-039 Change first_line to all 0x41 after the 0x80 command -> LCD shows the originally latched characters.
REQ-040 Pulse rst_n low during character 7 of row 0 -> all outputs 0 immediately; init sequence reruns; a new request produces a complete 68-pulse frame.
